// File: rtl/shift_sequencer.sv
// Sequencer for the registered 8-bit shifter: one shift/rotate request at a time, flags on response.
// Optional completed-operation counter (op_count) is built when SHIFT_SEQ_STATS_EN is defined.
//
// state | meaning
// IDLE  | ready for a request, shifter inputs parked at 0
// PASS1 | first shifter pass presented
// PASS2 | rotate only: capture pass-1 result, present the opposite-direction pass
// WAIT  | final shifter result available, build response
// RESP  | response held until consumer accepts
module shift_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [2:0] req_amt,
    input  logic [7:0] req_data,
    output logic       sh_fill,
    output logic       sh_dir,
    output logic [2:0] sh_s,
    output logic [7:0] sh_d,
    input  logic [7:0] sh_q,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       rsp_carry,
    output logic       rsp_err
`ifdef SHIFT_SEQ_STATS_EN
    ,
    output logic [COUNT_W-1:0] op_count
`endif
);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS1,
        S_PASS2,
        S_WAIT,
        S_RESP
    } state_t;

    if (COUNT_W < 1) begin : g_bad_count_w
        $error("shift_sequencer: COUNT_W must be at least 1");
    end

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_r;
    logic [2:0] amt_r;
    logic [7:0] data_r;
    logic [7:0] acc;
    logic       accept;
    logic       req_illegal;
    logic       two_pass;
    logic [7:0] result;

    function automatic logic carry_of(input logic [2:0] op, input logic [2:0] amt,
                                      input logic [7:0] d);
        logic c;
        c = 1'b0;
        if (amt != 3'd0) begin
            if (op == OP_SLL || op == OP_ROL)
                c = d[3'(4'd8 - {1'b0, amt})];
            else
                c = d[amt - 3'd1];
        end
        return c;
    endfunction

    assign req_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);
    assign accept      = req_valid && req_ready;
    assign req_illegal = (req_op > OP_ROR);
    assign two_pass    = (op_r == OP_ROL || op_r == OP_ROR) && (amt_r != 3'd0);
    assign result      = two_pass ? (sh_q | acc) : sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = req_illegal ? S_RESP : S_PASS1;
            S_PASS1: state_nxt = two_pass ? S_PASS2 : S_WAIT;
            S_PASS2: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shifter inputs are registered so they are stable for the whole cycle the shifter samples them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 3'd0;
            amt_r     <= 3'd0;
            data_r    <= 8'd0;
            acc       <= 8'd0;
            sh_fill   <= 1'b0;
            sh_dir    <= 1'b0;
            sh_s      <= 3'd0;
            sh_d      <= 8'd0;
            rsp_data  <= 8'd0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r   <= req_op;
                        amt_r  <= req_amt;
                        data_r <= req_data;
                        if (req_illegal) begin
                            rsp_data  <= req_data;
                            rsp_zero  <= (req_data == 8'd0);
                            rsp_carry <= 1'b0;
                            rsp_err   <= 1'b1;
                        end else begin
                            sh_dir  <= (req_op == OP_SRL || req_op == OP_SRA || req_op == OP_ROR);
                            sh_fill <= (req_op == OP_SRA) && req_data[7];
                            sh_s    <= req_amt;
                            sh_d    <= req_data;
                        end
                    end
                end
                S_PASS1: begin
                    if (two_pass) begin
                        sh_dir  <= ~sh_dir;
                        sh_fill <= 1'b0;
                        sh_s    <= 3'(4'd8 - {1'b0, amt_r});
                    end
                end
                S_PASS2: acc <= sh_q;
                S_WAIT: begin
                    rsp_data  <= result;
                    rsp_zero  <= (result == 8'd0);
                    rsp_carry <= carry_of(op_r, amt_r, data_r);
                    rsp_err   <= 1'b0;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        sh_fill <= 1'b0;
                        sh_dir  <= 1'b0;
                        sh_s    <= 3'd0;
                        sh_d    <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (rsp_valid && rsp_ready && (op_count != {COUNT_W{1'b1}}))
            op_count <= op_count + 1'b1;
    end
`endif

endmodule
